fast_frame_ctrl: RTL and testbench
==================================

# fast_frame_ctrl

Frame-level sequencer for the FAST front end. It accepts a pixel stream from the ARM DMA using a valid/ready handshake and drives the 7x7 line-buffer window generator through its clock enable. It tracks the raster position and reports, cycle-aligned with the window, whether the window is a complete patch and which pixel sits at its centre. Downstream backpressure stalls intake, so the line buffer never advances while the FAST detector is busy.

## Interface
- COL_NUM, 640, pixels per line (≤1024)
- ROW_NUM, 480, lines per frame (≤1024)
- PATCH_SIZE, 7, window edge; HALF = PATCH_SIZE/2 = 3
- PIXEL_WIDTH, 8, pixel bits
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse; arms capture of one frame
- s_valid  in  1  DMA pixel valid
- s_data  in  PIXEL_WIDTH  DMA pixel
- s_last  in  1  DMA marks final pixel of frame
- s_ready  out  1  controller accepts pixel
- m_ready  in  1  FAST detector can take a patch
- lb_ce  out  1  line-buffer clock enable
- lb_data  out  PIXEL_WIDTH  line-buffer pixel input
- patch_vld  out  1  window is a full patch (one-cycle pulse)
- ctr_x  out  10  centre column of the current patch
- ctr_y  out  10  centre row of the current patch
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse after the last pixel
- frame_cnt  out  16  completed frames, wraps at 0xFFFF→0
- err  out  1  sticky s_last mismatch flag

## Operation
- States: IDLE, RUN.
  - IDLE→RUN on start; col, row and err are cleared.
  - RUN→IDLE on acceptance of pixel (COL_NUM-1, ROW_NUM-1).
  - start in RUN is ignored.
- s_ready = (state==RUN) & m_ready, combinational. accept = s_valid & s_ready.
- lb_ce = accept and lb_data = s_data, both combinational pass-through. No line-buffer advance occurs without accept.
- Position counters col and row. On accept:
  - col increments; at COL_NUM-1 it wraps to 0 and row increments.
  - row wraps to 0 at ROW_NUM-1 together with the return to IDLE.
- Patch qualification on accept of pixel (c, r): full = (c ≥ 2·HALF) & (r ≥ 2·HALF).
  - Next cycle: patch_vld = full, ctr_x = c-HALF, ctr_y = r-HALF.
  - ctr_x/ctr_y hold their value when no accept occurs.
  - Columns with c < 2·HALF straddle two lines and never qualify.
- Frame end: on accept of the final pixel, frame_done pulses in the next cycle and frame_cnt increments.
  - No flush is needed: the last valid centre is (COL_NUM-1-HALF, ROW_NUM-1-HALF), which is emitted on the final pixel itself.
- s_valid in IDLE is not accepted (s_ready=0); the data is left for the next frame.
- The line buffer's window content is stale between frames. patch_vld cannot assert until row 2·HALF, so no stale data is qualified.

## Timing
- Reset values: s_ready 0, lb_ce 0, lb_data follows s_data, patch_vld 0, ctr_x 0, ctr_y 0, busy 0, frame_done 0, frame_cnt 0, err 0; state IDLE; col and row 0.
- Latency: accept at cycle t → window updated at edge t+1 → patch_vld, ctr_x and ctr_y valid during cycle t+1.
- busy = (state==RUN), registered; it rises the cycle after start.
- m_ready low stalls intake in the same cycle (combinational); patch_vld does not assert during the stall.
- start coincident with the final accept: the frame ends and start is ignored.
- rst_n asserted mid-frame returns all outputs to their reset values immediately. The partial frame is discarded and frame_cnt is not incremented.

## Configuration
- FAST_FRAME_CTRL_LAST_CHECK_EN defined: err sets when s_last=1 on an accept that is not the final pixel, or s_last=0 on the final pixel. err holds until the next IDLE→RUN.
- Not defined: s_last is ignored and err is tied to 0.
- The frame length is always parameter-driven; s_last never terminates a frame.

## Structure
- Package fast_pkg holds:
  - the default COL_NUM, ROW_NUM and PATCH_SIZE;
  - derived HALF;
  - COORD_W=10;
  - the state enum (IDLE, RUN).
- Sub-module fast_pos_counter: col/row counter with enable, line wrap and last-pixel flag; instantiated once.

## Test plan
- COL_NUM=8, ROW_NUM=8, start, 64 back-to-back pixels with m_ready=1 → exactly 4 patch_vld pulses with centres (3,3), (4,3), (3,4), (4,4); frame_done one cycle after pixel 63; frame_cnt=1.
- Same frame, m_ready low for 5 cycles after pixel 50 → s_ready and lb_ce low for those 5 cycles, no lost or duplicated pixel, same 4 centres.
- s_valid asserted before start → s_ready=0 and lb_ce=0 until busy is set.
- LAST_CHECK_EN, s_last on pixel 20 → err=1 from the next cycle, frame still completes at pixel 63; the next start clears err.
- rst_n low at pixel 40 → all outputs at reset values, frame_cnt=0; a fresh frame then yields the 4 centres again.
- frame_cnt preset through 65535 frames (or forced) → wraps to 0 on the next frame_done.

Source files
------------

// File: rtl/fast_pkg.sv
// rtl/fast_pkg.sv - shared defaults, derived constants and state type for the FAST frame controller
package fast_pkg;

  localparam int DEF_COL_NUM    = 640;
  localparam int DEF_ROW_NUM    = 480;
  localparam int DEF_PATCH_SIZE = 7;
  localparam int HALF           = DEF_PATCH_SIZE / 2;
  localparam int COORD_W        = 10;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/fast_pos_counter.sv
// rtl/fast_pos_counter.sv - raster column/row counter with line wrap and last-pixel flag
module fast_pos_counter
  import fast_pkg::*;
#(
  parameter int COL_NUM = DEF_COL_NUM,
  parameter int ROW_NUM = DEF_ROW_NUM
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               en,
  output logic [COORD_W-1:0] col,
  output logic [COORD_W-1:0] row,
  output logic               last
);

  localparam logic [COORD_W-1:0] COL_MAX = COORD_W'(COL_NUM - 1);
  localparam logic [COORD_W-1:0] ROW_MAX = COORD_W'(ROW_NUM - 1);

  logic col_end;

  // end-of-line and end-of-frame decode of the current position
  always_comb begin
    col_end = (col == COL_MAX);
    last    = col_end & (row == ROW_MAX);
  end

  // advance one pixel per enable; the frame's last pixel returns both counters to 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (clr) begin
      col <= '0;
      row <= '0;
    end else if (en) begin
      if (col_end) begin
        col <= '0;
        row <= last ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fast_frame_ctrl.sv
// rtl/fast_frame_ctrl.sv - FAST frame sequencer (option: FAST_FRAME_CTRL_LAST_CHECK_EN enables s_last checking)
module fast_frame_ctrl
  import fast_pkg::*;
#(
  parameter int COL_NUM     = DEF_COL_NUM,
  parameter int ROW_NUM     = DEF_ROW_NUM,
  parameter int PATCH_SIZE  = DEF_PATCH_SIZE,
  parameter int PIXEL_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   s_valid,
  input  logic [PIXEL_WIDTH-1:0] s_data,
  input  logic                   s_last,
  output logic                   s_ready,
  input  logic                   m_ready,
  output logic                   lb_ce,
  output logic [PIXEL_WIDTH-1:0] lb_data,
  output logic                   patch_vld,
  output logic [COORD_W-1:0]     ctr_x,
  output logic [COORD_W-1:0]     ctr_y,
  output logic                   busy,
  output logic                   frame_done,
  output logic [15:0]            frame_cnt,
  output logic                   err
);

  localparam int HALF_SZ = PATCH_SIZE / 2;
  localparam logic [COORD_W-1:0] EDGE = COORD_W'(2 * HALF_SZ);
  localparam logic [COORD_W-1:0] OFFS = COORD_W'(HALF_SZ);

  state_t             state;
  state_t             state_nxt;
  logic               accept;
  logic               go;
  logic               last;
  logic               full;
  logic [COORD_W-1:0] col;
  logic [COORD_W-1:0] row;

  fast_pos_counter #(
    .COL_NUM (COL_NUM),
    .ROW_NUM (ROW_NUM)
  ) u_pos (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (go),
    .en    (accept),
    .col   (col),
    .row   (row),
    .last  (last)
  );

  // handshake and line-buffer pass-through; the line buffer only moves on an accepted pixel
  always_comb begin
    busy    = (state == RUN);
    s_ready = busy & m_ready;
    accept  = s_valid & s_ready;
    go      = (state == IDLE) & start;
    lb_ce   = accept;
    lb_data = s_data;
    full    = (col >= EDGE) & (row >= EDGE);
  end

  // next state: arm on start, finish on acceptance of the final pixel
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (accept && last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // patch qualification and centre, aligned with the window updated by this accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      patch_vld <= 1'b0;
      ctr_x     <= '0;
      ctr_y     <= '0;
    end else begin
      patch_vld <= accept & full;
      if (accept) begin
        ctr_x <= col - OFFS;
        ctr_y <= row - OFFS;
      end
    end
  end

  // frame completion pulse and wrapping frame counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      frame_done <= accept & last;
      if (accept && last) frame_cnt <= frame_cnt + 16'd1;
    end
  end

`ifdef FAST_FRAME_CTRL_LAST_CHECK_EN
  // sticky flag when s_last disagrees with the counted frame end; cleared when a frame is armed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         err <= 1'b0;
    else if (go)                        err <= 1'b0;
    else if (accept && (s_last != last)) err <= 1'b1;
  end
`else
  logic unused_last;
  assign unused_last = s_last;
  assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_fast_frame_ctrl.sv
// tb/tb_fast_frame_ctrl.sv - directed self-checking bench for fast_frame_ctrl on an 8x8 frame
module tb_fast_frame_ctrl;

  localparam int NPIX = 64;
`ifdef FAST_FRAME_CTRL_LAST_CHECK_EN
  localparam logic LAST_CHK = 1'b1;
`else
  localparam logic LAST_CHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_last = 1'b0;
  logic       m_ready = 1'b0;
  logic       s_ready;
  logic       lb_ce;
  logic [7:0] lb_data;
  logic       patch_vld;
  logic [9:0] ctr_x;
  logic [9:0] ctr_y;
  logic       busy;
  logic       frame_done;
  logic [15:0] frame_cnt;
  logic       err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_acc_cyc = -1;
  int fd_cyc = -100;
  int fd_n = 0;
  logic [7:0]  acc_q[$];
  logic [19:0] pv_q[$];
  logic [19:0] exp_pv [4];

  always #5 clk = ~clk;

  fast_frame_ctrl #(
    .COL_NUM     (8),
    .ROW_NUM     (8),
    .PATCH_SIZE  (7),
    .PIXEL_WIDTH (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_last     (s_last),
    .s_ready    (s_ready),
    .m_ready    (m_ready),
    .lb_ce      (lb_ce),
    .lb_data    (lb_data),
    .patch_vld  (patch_vld),
    .ctr_x      (ctr_x),
    .ctr_y      (ctr_y),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt),
    .err        (err)
  );

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n) begin
      if (lb_ce) begin
        acc_q.push_back(lb_data);
        if (lb_data == 8'd63) last_acc_cyc = cyc;
      end
      if (patch_vld) pv_q.push_back({ctr_y, ctr_x});
      if (frame_done) begin
        fd_cyc = cyc;
        fd_n++;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_s_ready"},    32'(s_ready),    32'd0);
    check({tag, "_lb_ce"},      32'(lb_ce),      32'd0);
    check({tag, "_lb_data"},    32'(lb_data),    32'(s_data));
    check({tag, "_patch_vld"},  32'(patch_vld),  32'd0);
    check({tag, "_ctr_x"},      32'(ctr_x),      32'd0);
    check({tag, "_ctr_y"},      32'(ctr_y),      32'd0);
    check({tag, "_busy"},       32'(busy),       32'd0);
    check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    check({tag, "_frame_cnt"},  32'(frame_cnt),  32'd0);
    check({tag, "_err"},        32'(err),        32'd0);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_rise", 32'(busy), 32'd1);
  endtask

  task automatic send_pixels(input int stall_at, input int bad_last_at, input int abort_at,
                             input int stray_start_at);
    acc_q.delete();
    pv_q.delete();
    last_acc_cyc = -1;
    fd_cyc = -100;
    fd_n = 0;
    m_ready = 1'b1;
    for (int i = 0; i < NPIX; i++) begin
      s_valid = 1'b1;
      s_data  = 8'(i);
      s_last  = (i == NPIX - 1) || (i == bad_last_at);
      if (stall_at >= 0 && i == stall_at + 1) begin
        m_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          check("stall_s_ready", 32'(s_ready), 32'd0);
          check("stall_lb_ce", 32'(lb_ce), 32'd0);
          tick();
        end
        m_ready = 1'b1;
      end
      start = (i == stray_start_at);
      tick();
      start = 1'b0;
      if (i == bad_last_at) check("err_after_bad_last", 32'(err), 32'(LAST_CHK));
      if (i == abort_at) begin
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        #1;
        check_reset("abort");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        return;
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    repeat (3) tick();
  endtask

  task automatic check_frame(input string tag, input int exp_cnt);
    check({tag, "_pix_count"}, 32'(acc_q.size()), 32'(NPIX));
    for (int i = 0; i < acc_q.size() && i < NPIX; i++)
      check({tag, "_pix_order"}, 32'(acc_q[i]), 32'(i));
    check({tag, "_patch_count"}, 32'(pv_q.size()), 32'd4);
    for (int i = 0; i < pv_q.size() && i < 4; i++)
      check({tag, "_centre"}, 32'(pv_q[i]), 32'(exp_pv[i]));
    check({tag, "_done_latency"}, 32'(fd_cyc - last_acc_cyc), 32'd1);
    check({tag, "_done_pulses"}, 32'(fd_n), 32'd1);
    check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(exp_cnt));
    check({tag, "_busy_low"}, 32'(busy), 32'd0);
    check({tag, "_ctr_hold"}, 32'({ctr_y, ctr_x}), 32'({10'd4, 10'd4}));
    check({tag, "_patch_idle"}, 32'(patch_vld), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout cycles=%0d", cyc);
    $fatal(1);
  end

  initial begin
    exp_pv[0] = {10'd3, 10'd3};
    exp_pv[1] = {10'd3, 10'd4};
    exp_pv[2] = {10'd4, 10'd3};
    exp_pv[3] = {10'd4, 10'd4};

    s_data  = 8'h5A;
    m_ready = 1'b1;
    rst_n   = 1'b0;
    repeat (2) tick();
    check_reset("rst");
    rst_n = 1'b1;
    tick();
    check_reset("post_rst");

    s_valid = 1'b1;
    s_data  = 8'h00;
    repeat (3) begin
      @(negedge clk);
      check("pre_start_s_ready", 32'(s_ready), 32'd0);
      check("pre_start_lb_ce", 32'(lb_ce), 32'd0);
      tick();
    end
    start = 1'b1;
    @(negedge clk);
    check("start_cycle_s_ready", 32'(s_ready), 32'd0);
    check("start_cycle_busy", 32'(busy), 32'd0);
    tick();
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    send_pixels(-1, -1, -1, -1);
    check_frame("f1", 1);
    check("f1_err", 32'(err), 32'd0);

    do_start();
    send_pixels(50, -1, -1, 30);
    check_frame("f2_stall", 2);

    do_start();
    send_pixels(-1, 20, -1, -1);
    check_frame("f3_badlast", 3);
    check("err_sticky", 32'(err), 32'(LAST_CHK));

    do_start();
    check("err_cleared_on_start", 32'(err), 32'd0);
    send_pixels(-1, -1, 40, -1);
    check("abort_frame_cnt", 32'(frame_cnt), 32'd0);

    do_start();
    send_pixels(-1, -1, -1, -1);
    check_frame("f5_fresh", 1);

    force dut.frame_cnt = 16'hFFFF;
    tick();
    release dut.frame_cnt;
    tick();
    check("preset_frame_cnt", 32'(frame_cnt), 32'h0000FFFF);
    do_start();
    send_pixels(-1, -1, -1, -1);
    check_frame("f6_wrap", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
